// File: rtl/mw_stage_unit.sv
// mw_stage_unit: M-stage data memory access (aligned loads/stores, extension) plus M/W pipeline register
module mw_stage_unit #(
  parameter int DM_WORDS = 3072,
  parameter int DM_AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_M,
  input  logic [31:0] pc_M,
  input  logic [31:0] pc4_M,
  input  logic [31:0] RD2_M,
  input  logic [31:0] outC_M,
  input  logic [3:0]  Tnew_M,
  output logic [31:0] Instr_W,
  output logic [31:0] pc_W,
  output logic [31:0] pc4_W,
  output logic [31:0] outC_W,
  output logic [31:0] DMRD_W,
  output logic [3:0]  Tnew_W,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata
);
  localparam logic [31:0] LIMIT = 32'(4 * DM_WORDS);
  logic [31:0] mem [DM_WORDS];
  logic [5:0] op;
  logic [1:0] off;
  logic [DM_AW-1:0] idx;
  logic is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
  logic is_word, is_half, is_store, aligned, ok;
  logic [31:0] old, merged, ld;
  logic [15:0] half_v;
  logic [7:0] byte_v;
  assign op     = Instr_M[31:26];
  assign off    = outC_M[1:0];
  assign idx    = outC_M[DM_AW+1:2];
  assign is_lw  = op == 6'b100011;
  assign is_lh  = op == 6'b100001;
  assign is_lhu = op == 6'b100101;
  assign is_lb  = op == 6'b100000;
  assign is_lbu = op == 6'b100100;
  assign is_sw  = op == 6'b101011;
  assign is_sh  = op == 6'b101001;
  assign is_sb  = op == 6'b101000;
  assign is_word  = is_lw | is_sw;
  assign is_half  = is_lh | is_lhu | is_sh;
  assign is_store = is_sw | is_sh | is_sb;
  assign aligned  = is_word ? off == 2'b00 : is_half ? !off[0] : 1'b1;
  // Out-of-range indices can still fit in DM_AW bits, so the read is gated by the range check
  assign ok     = (outC_M < LIMIT) & aligned;
  assign old    = ok ? mem[idx] : '0;
  assign half_v = old[{off[1], 4'b0} +: 16];
  assign byte_v = old[{off, 3'b0} +: 8];
  always_comb begin
    merged = old;
    if (is_sw) merged = RD2_M;
    else if (is_sh) merged[{off[1], 4'b0} +: 16] = RD2_M[15:0];
    else if (is_sb) merged[{off, 3'b0} +: 8] = RD2_M[7:0];
  end
  assign ld = !ok   ? '0 :
              is_lw  ? old :
              is_lh  ? {{16{half_v[15]}}, half_v} :
              is_lhu ? {16'b0, half_v} :
              is_lb  ? {{24{byte_v[7]}}, byte_v} :
              is_lbu ? {24'b0, byte_v} : '0;
  assign dm_we    = reset & is_store & ok;
  assign dm_addr  = dm_we ? {outC_M[31:2], 2'b00} : '0;
  assign dm_wdata = dm_we ? merged : '0;
  always_ff @(posedge clk)
    if (dm_we) mem[idx] <= merged;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      Instr_W <= '0;
      pc_W    <= '0;
      pc4_W   <= '0;
      outC_W  <= '0;
      DMRD_W  <= '0;
      Tnew_W  <= '0;
    end else begin
      Instr_W <= Instr_M;
      pc_W    <= pc_M;
      pc4_W   <= pc4_M;
      outC_W  <= outC_M;
      DMRD_W  <= ld;
      Tnew_W  <= (Tnew_M != 4'd0) ? Tnew_M - 4'd1 : 4'd0;
    end
endmodule

// File: tb/tb_mw_stage_unit.sv
// tb_mw_stage_unit: directed vector table plus reset sequences for mw_stage_unit
module tb_mw_stage_unit;
  logic clk = 0, reset = 0;
  logic [31:0] Instr_M = 0, pc_M = 0, pc4_M = 0, RD2_M = 0, outC_M = 0;
  logic [3:0] Tnew_M = 0;
  logic [31:0] Instr_W, pc_W, pc4_W, outC_W, DMRD_W, dm_addr, dm_wdata;
  logic [3:0] Tnew_W;
  logic dm_we;
  int n_tests = 0, n_fail = 0;

  localparam logic [31:0] LW = 32'h8C000000, LH = 32'h84000000, LHU = 32'h94000000,
    LB = 32'h80000000, LBU = 32'h90000000, SW = 32'hAC000000, SH = 32'hA4000000, SB = 32'hA0000000;

  mw_stage_unit dut (
    .clk(clk), .reset(reset), .Instr_M(Instr_M), .pc_M(pc_M), .pc4_M(pc4_M),
    .RD2_M(RD2_M), .outC_M(outC_M), .Tnew_M(Tnew_M), .Instr_W(Instr_W), .pc_W(pc_W),
    .pc4_W(pc4_W), .outC_W(outC_W), .DMRD_W(DMRD_W), .Tnew_W(Tnew_W), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, addr, data;
    logic [3:0]  tnew;
    logic        we;
    logic [31:0] wdata, dmrd;
    logic [3:0]  tnew_w;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, addr, data, input logic [3:0] tnew, input logic [31:0] pc);
    Instr_M = instr; outC_M = addr; RD2_M = data; Tnew_M = tnew; pc_M = pc; pc4_M = pc + 4;
  endtask

  vec_t v[$];

  initial begin
    // reset held low with arbitrary inputs while the clock toggles
    drive(SW, 32'h10, 32'hFFFFFFFF, 4'd9, 32'h1234);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", Instr_W, 0); chk("rst_pc", pc_W, 0); chk("rst_pc4", pc4_W, 0);
    chk("rst_outc", outC_W, 0); chk("rst_dmrd", DMRD_W, 0); chk("rst_tnew", {28'b0, Tnew_W}, 0);
    chk("rst_we", {31'b0, dm_we}, 0);
    @(negedge clk);
    reset = 1;
    drive(LW, 32'h3000, 0, 4'd2, 32'h3000);
    @(posedge clk); #1;
    chk("rel_instr", Instr_W, LW); chk("rel_tnew", {28'b0, Tnew_W}, 1);
    chk("rel_pc4", pc4_W, 32'h3004);

    v.push_back('{SW,  32'h10, 32'h12345678, 4'd2, 1'b1, 32'h12345678, 32'h0, 4'd1});
    v.push_back('{LW,  32'h10, 32'h0,        4'd0, 1'b0, 32'h0, 32'h12345678, 4'd0});
    v.push_back('{SB,  32'h13, 32'h000000AB, 4'd1, 1'b1, 32'hAB345678, 32'h0, 4'd0});
    v.push_back('{SH,  32'h10, 32'hFFFF8001, 4'd3, 1'b1, 32'hAB348001, 32'h0, 4'd2});
    v.push_back('{LB,  32'h13, 32'h0,        4'd15, 1'b0, 32'h0, 32'hFFFFFFAB, 4'd14});
    v.push_back('{LBU, 32'h13, 32'h0,        4'd0, 1'b0, 32'h0, 32'h000000AB, 4'd0});
    v.push_back('{LH,  32'h10, 32'h0,        4'd0, 1'b0, 32'h0, 32'hFFFF8001, 4'd0});
    v.push_back('{LHU, 32'h10, 32'h0,        4'd0, 1'b0, 32'h0, 32'h00008001, 4'd0});
    v.push_back('{LH,  32'h12, 32'h0,        4'd0, 1'b0, 32'h0, 32'hFFFFAB34, 4'd0});
    v.push_back('{LBU, 32'h11, 32'h0,        4'd0, 1'b0, 32'h0, 32'h00000080, 4'd0});
    v.push_back('{SW,  32'h12, 32'h55555555, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0});
    v.push_back('{SH,  32'h11, 32'h55555555, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0});
    v.push_back('{LW,  32'h10, 32'h0,        4'd0, 1'b0, 32'h0, 32'hAB348001, 4'd0});
    v.push_back('{LH,  32'h11, 32'h0,        4'd0, 1'b0, 32'h0, 32'h0, 4'd0});
    v.push_back('{SB,  32'h11, 32'h0000007F, 4'd0, 1'b1, 32'hAB347F01, 32'h0, 4'd0});
    v.push_back('{LB,  32'h11, 32'h0,        4'd0, 1'b0, 32'h0, 32'h0000007F, 4'd0});
    v.push_back('{SW,  32'h3000, 32'h11111111, 4'd0, 1'b0, 32'h0, 32'h0, 4'd0});
    v.push_back('{SW,  32'h2FFC, 32'hCAFEF00D, 4'd0, 1'b1, 32'hCAFEF00D, 32'h0, 4'd0});
    v.push_back('{LW,  32'h2FFC, 32'h0,      4'd0, 1'b0, 32'h0, 32'hCAFEF00D, 4'd0});
    v.push_back('{LW,  32'h3000, 32'h0,      4'd0, 1'b0, 32'h0, 32'h0, 4'd0});
    v.push_back('{LW,  32'hFFFFFFFC, 32'h0,  4'd0, 1'b0, 32'h0, 32'h0, 4'd0});
    v.push_back('{32'h0, 32'h10, 32'hFFFFFFFF, 4'd1, 1'b0, 32'h0, 32'h0, 4'd0});
    v.push_back('{SW,  32'h20, 32'h01020304, 4'd0, 1'b1, 32'h01020304, 32'h0, 4'd0});

    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].instr, v[i].addr, v[i].data, v[i].tnew, 32'h400 + 4 * i);
      #1;
      chk($sformatf("v%0d_we", i), {31'b0, dm_we}, {31'b0, v[i].we});
      chk($sformatf("v%0d_addr", i), dm_addr, v[i].we ? {v[i].addr[31:2], 2'b00} : 32'h0);
      chk($sformatf("v%0d_wdata", i), dm_wdata, v[i].wdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_dmrd", i), DMRD_W, v[i].dmrd);
      chk($sformatf("v%0d_tnew", i), {28'b0, Tnew_W}, {28'b0, v[i].tnew_w});
      chk($sformatf("v%0d_instr", i), Instr_W, v[i].instr);
      chk($sformatf("v%0d_outc", i), outC_W, v[i].addr);
      chk($sformatf("v%0d_pc", i), pc_W, 32'h400 + 4 * i);
      chk($sformatf("v%0d_pc4", i), pc4_W, 32'h404 + 4 * i);
    end

    // reset pulled mid-store: outputs clear at once and the write is dropped
    @(negedge clk);
    drive(SW, 32'h20, 32'hDEADBEEF, 4'd5, 32'h800);
    #1;
    chk("ar_we_pre", {31'b0, dm_we}, 1);
    #1 reset = 0;
    #1;
    chk("ar_instr", Instr_W, 0); chk("ar_outc", outC_W, 0); chk("ar_pc", pc_W, 0);
    chk("ar_we", {31'b0, dm_we}, 0); chk("ar_addr", dm_addr, 0); chk("ar_wdata", dm_wdata, 0);
    @(posedge clk); #1;
    chk("ar_hold_instr", Instr_W, 0); chk("ar_hold_tnew", {28'b0, Tnew_W}, 0);
    @(negedge clk);
    reset = 1;
    drive(LW, 32'h20, 0, 4'd4, 32'h804);
    @(posedge clk); #1;
    chk("ar_lw", DMRD_W, 32'h01020304); chk("ar_lw_tnew", {28'b0, Tnew_W}, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
